cdc_fifo_read_port: RTL and testbench

Read-domain half of the dual-clock FIFO, downstream of the write-pointer state block. It synchronises the write pointer (Gray) into the read clock domain and owns the binary and Gray read pointers. It fetches words from the FIFO memory's asynchronous read port into an output register and presents them on a valid/ready stream. It exports its registered Gray read pointer back to the write domain for the full check there.

---
 rtl/cdc_fifo_pkg.sv | 30 +++
 rtl/cdc_fifo_read_port_if.sv | 27 ++
 rtl/cdc_fifo_sync.sv | 19 +
 rtl/cdc_fifo_read_port.sv | 67 ++++++
 tb/tb_cdc_fifo_read_port.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cdc_fifo_pkg.sv
// Shared definitions for the dual-clock FIFO: pointer width defaults and
// Gray/binary conversion used on both sides of the clock boundary.
package cdc_fifo_pkg;

  localparam int ADDRESS_WIDTH_DEFAULT = 4;
  localparam int DATA_WIDTH_DEFAULT    = 8;
  localparam int POINTER_MAX_WIDTH     = 16;

  typedef logic [POINTER_MAX_WIDTH-1:0] pointer_t;

  function automatic pointer_t binary_to_gray(input pointer_t b, input int address_width);
    pointer_t mask;
    mask = (pointer_t'(1) << address_width) - pointer_t'(1);
    return (b ^ (b >> 1)) & mask;
  endfunction

  // Prefix XOR from the MSB down; bits above address_width stay zero.
  function automatic pointer_t gray_to_binary(input pointer_t g, input int address_width);
    pointer_t b;
    logic     acc;
    b   = '0;
    acc = 1'b0;
    for (int i = POINTER_MAX_WIDTH - 1; i >= 0; i--) begin
      if (i < address_width) acc = acc ^ g[i];
      b[i] = acc;
    end
    return b;
  endfunction

endpackage

// File: rtl/cdc_fifo_read_port_if.sv
// Read-port bus: write-pointer input, memory read port, and the consumer stream.
interface cdc_fifo_read_port_if
  import cdc_fifo_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEFAULT,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT
);
  logic [ADDRESS_WIDTH-1:0] write_address_gray;
  logic [ADDRESS_WIDTH-1:0] read_address;
  logic [ADDRESS_WIDTH-1:0] read_address_gray;
  logic [DATA_WIDTH-1:0]    read_data;
  logic [DATA_WIDTH-1:0]    data;
  logic                     valid;
  logic                     ready;
  logic                     empty;
  logic [ADDRESS_WIDTH:0]   level;

  modport master (
    input  write_address_gray, read_data, ready,
    output read_address, read_address_gray, data, valid, empty, level
  );

  modport slave (
    output write_address_gray, read_data, ready,
    input  read_address, read_address_gray, data, valid, empty, level
  );
endinterface

// File: rtl/cdc_fifo_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into this clock.
module cdc_fifo_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) chain <= '0;
    else          chain <= {chain[SYNC_STAGES-2:0], async_in};
  end

  assign sync_out = chain[SYNC_STAGES-1];
endmodule

// File: rtl/cdc_fifo_read_port.sv
// Read-domain half of the dual-clock FIFO: syncs the write pointer, owns the
// read pointers, and registers memory words onto a valid/ready stream.
module cdc_fifo_read_port
  import cdc_fifo_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEFAULT,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  cdc_fifo_read_port_if.master  bus
);
  logic [ADDRESS_WIDTH-1:0] write_sync_gray;
  logic [ADDRESS_WIDTH-1:0] write_sync;
  logic [ADDRESS_WIDTH-1:0] read_address_q;
  logic [ADDRESS_WIDTH-1:0] read_address_next;
  logic [ADDRESS_WIDTH-1:0] read_address_gray_q;
  logic [ADDRESS_WIDTH-1:0] occupancy;
  logic [DATA_WIDTH-1:0]    data_q;
  logic                     valid_q;
  logic                     empty;
  logic                     pop;

  cdc_fifo_sync #(
    .WIDTH       (ADDRESS_WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_write_sync (
    .clock    (clock),
    .reset_n  (reset_n),
    .async_in (bus.write_address_gray),
    .sync_out (write_sync_gray)
  );

  always_comb begin
    write_sync        = ADDRESS_WIDTH'(gray_to_binary(pointer_t'(write_sync_gray), ADDRESS_WIDTH));
    empty             = (read_address_q == write_sync);
    pop               = !empty && (!valid_q || bus.ready);
    read_address_next = read_address_q + ADDRESS_WIDTH'(1);
    occupancy         = write_sync - read_address_q;
  end

  // The Gray pointer is registered alongside the binary one so the write
  // domain only ever samples a flop output.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_address_q      <= '0;
      read_address_gray_q <= '0;
      data_q              <= '0;
      valid_q             <= 1'b0;
    end else if (pop) begin
      data_q              <= bus.read_data;
      valid_q             <= 1'b1;
      read_address_q      <= read_address_next;
      read_address_gray_q <= ADDRESS_WIDTH'(binary_to_gray(pointer_t'(read_address_next), ADDRESS_WIDTH));
    end else if (valid_q && bus.ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.read_address      = read_address_q;
  assign bus.read_address_gray = read_address_gray_q;
  assign bus.data              = data_q;
  assign bus.valid             = valid_q;
  assign bus.empty             = empty;
  assign bus.level             = {1'b0, occupancy} + (ADDRESS_WIDTH+1)'(valid_q);
endmodule

// File: tb/tb_cdc_fifo_read_port.sv
// Directed bench for cdc_fifo_read_port with a queue-level reference model.
module tb_cdc_fifo_read_port;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int SYNC_STAGES = 2;
  localparam int DEPTH = 1 << AW;

  logic clock;
  logic reset_n;

  cdc_fifo_read_port_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  cdc_fifo_read_port #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .SYNC_STAGES   (SYNC_STAGES)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [DW-1:0] mem [DEPTH];
  assign bus.read_data = mem[bus.read_address];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int wp      = 0;

  // model: write pointer as seen after the synchroniser delay, read count, output register
  int            m_seen [SYNC_STAGES];
  int            m_rd;
  int            m_avail;
  bit            mv;
  logic [DW-1:0] md;

  logic [DW-1:0] got[$];
  int            got_cyc[$];
  logic [AW-1:0] prev_ra, prev_g;

  function automatic logic [AW-1:0] gray(input int b);
    logic [AW-1:0] x;
    x = AW'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_wp(input int v);
    wp = v % DEPTH;
    bus.write_address_gray = gray(wp);
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) m_seen[i] = 0;
      m_rd = 0;
      mv   = 1'b0;
      md   = '0;
    end else begin
      cyc++;
      m_avail = (m_seen[SYNC_STAGES-1] - m_rd + DEPTH) % DEPTH;
      if (m_avail != 0 && (!mv || bus.ready)) begin
        md   = mem[m_rd];
        mv   = 1'b1;
        m_rd = (m_rd + 1) % DEPTH;
      end else if (mv && bus.ready) begin
        mv = 1'b0;
      end
      for (int i = SYNC_STAGES - 1; i > 0; i--) m_seen[i] = m_seen[i-1];
      m_seen[0] = wp;
    end
  end

  always @(negedge clock) begin
    chk("read_address", int'(bus.read_address), m_rd);
    chk("read_address_gray", int'(bus.read_address_gray), int'(gray(m_rd)));
    chk("valid", int'(bus.valid), int'(mv));
    chk("data", int'(bus.data), int'(md));
    chk("empty", int'(bus.empty), int'(m_seen[SYNC_STAGES-1] == m_rd));
    chk("level", int'(bus.level), (m_seen[SYNC_STAGES-1] - m_rd + DEPTH) % DEPTH + int'(mv));
    if (reset_n && bus.read_address != prev_ra)
      chk("gray_one_bit_step", $countones(bus.read_address_gray ^ prev_g), 1);
    prev_ra = bus.read_address;
    prev_g  = bus.read_address_gray;
    if (reset_n && bus.valid && bus.ready) begin
      got.push_back(bus.data);
      got_cyc.push_back(cyc);
    end
  end

  task automatic drain();
    int n;
    n = 0;
    repeat (SYNC_STAGES + 1) tick();
    while (!(bus.valid == 1'b0 && bus.empty == 1'b1) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_in_budget", int'(n < 200), 1);
  endtask

  task automatic do_reset();
    tick();
    reset_n   = 1'b0;
    bus.ready = 1'b0;
    set_wp(0);
    tick();
    reset_n = 1'b1;
    got.delete();
    got_cyc.delete();
  endtask

  task automatic chk_got(input string nm, input int base, input int n);
    chk({nm, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) chk(nm, int'(got[i]), base + i);
  endtask

  initial begin
    reset_n   = 1'b1;
    bus.ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(8'h10 + i);
    set_wp(5);

    // reset with a non-zero write pointer already present
    #1 reset_n = 1'b0;
    #1;
    chk("rst_valid", int'(bus.valid), 0);
    chk("rst_read_address", int'(bus.read_address), 0);
    chk("rst_read_address_gray", int'(bus.read_address_gray), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_level", int'(bus.level), 0);
    repeat (3) tick();
    reset_n = 1'b1;
    tick(); tick();
    chk("rel_valid_before_pop", int'(bus.valid), 0);
    chk("rel_level_synced", int'(bus.level), 5);
    tick();
    chk("rel_valid", int'(bus.valid), 1);
    chk("rel_data", int'(bus.data), 8'h10);
    chk("rel_level", int'(bus.level), 5);
    got.delete();
    got_cyc.delete();
    bus.ready = 1'b1;
    drain();
    chk_got("rel_words", 8'h10, 5);

    // streaming three words with ready held high
    do_reset();
    for (int i = 0; i < 3; i++) mem[i] = DW'(8'hA0 + i);
    bus.ready = 1'b1;
    set_wp(3);
    drain();
    chk_got("stream_words", 8'hA0, 3);
    if (got_cyc.size() == 3) chk("stream_back_to_back", got_cyc[2] - got_cyc[0], 2);
    chk("stream_read_address", int'(bus.read_address), 3);
    chk("stream_empty", int'(bus.empty), 1);
    chk("stream_valid", int'(bus.valid), 0);

    // backpressure
    do_reset();
    for (int i = 0; i < 4; i++) mem[i] = DW'(8'hB0 + i);
    set_wp(4);
    repeat (3) tick();
    repeat (5) tick();
    chk("bp_data", int'(bus.data), 8'hB0);
    chk("bp_valid", int'(bus.valid), 1);
    chk("bp_read_address", int'(bus.read_address), 1);
    chk("bp_level", int'(bus.level), 4);
    bus.ready = 1'b1;
    drain();
    chk_got("bp_words", 8'hB0, 4);

    // wrap-around from pointer 14, filled to capacity
    do_reset();
    for (int i = 0; i < 14; i++) mem[i] = DW'(8'h20 + i);
    bus.ready = 1'b1;
    set_wp(14);
    drain();
    chk("wrap_start_address", int'(bus.read_address), 14);
    bus.ready = 1'b0;
    got.delete();
    got_cyc.delete();
    for (int k = 0; k < 15; k++) mem[(14 + k) % DEPTH] = DW'(8'h40 + k);
    set_wp(14 + 15);
    repeat (3) tick();
    chk("wrap_level_full", int'(bus.level), 15);
    chk("wrap_first_data", int'(bus.data), 8'h40);
    bus.ready = 1'b1;
    drain();
    chk_got("wrap_words", 8'h40, 15);
    chk("wrap_end_address", int'(bus.read_address), 13);

    // full capacity from pointer 0
    do_reset();
    for (int i = 0; i < 15; i++) mem[i] = DW'(8'h60 + i);
    set_wp(15);
    tick(); tick();
    chk("full_level_pre_pop", int'(bus.level), 15);
    chk("full_valid_pre_pop", int'(bus.valid), 0);
    tick();
    chk("full_level_post_pop", int'(bus.level), 15);
    chk("full_read_address", int'(bus.read_address), 1);
    bus.ready = 1'b1;
    drain();
    chk("full_level_drained", int'(bus.level), 0);
    chk_got("full_words", 8'h60, 15);

    // asynchronous reset in the middle of a transfer
    do_reset();
    for (int i = 0; i < 9; i++) mem[i] = DW'(8'h80 + i);
    bus.ready = 1'b1;
    set_wp(6);
    drain();
    bus.ready = 1'b0;
    set_wp(9);
    repeat (3) tick();
    chk("mid_valid_before", int'(bus.valid), 1);
    chk("mid_address_before", int'(bus.read_address), 7);
    chk("mid_data_before", int'(bus.data), 8'h86);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(bus.valid), 0);
    chk("mid_rst_read_address", int'(bus.read_address), 0);
    chk("mid_rst_read_address_gray", int'(bus.read_address_gray), 0);
    chk("mid_rst_data", int'(bus.data), 0);
    chk("mid_rst_empty", int'(bus.empty), 1);
    chk("mid_rst_level", int'(bus.level), 0);
    set_wp(0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("mid_post_valid", int'(bus.valid), 0);
    chk("mid_post_address", int'(bus.read_address), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
